fv_cov_multi: RTL and testbench

FV_COV_MULTI -- requirements
Module: fv_cov_multi

---
 rtl/fv_cov_multi.sv | 169 ++++++++++++++++
 tb/tb_fv_cov_multi.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fv_cov_multi.sv
// Multi-lane instruction-class coverage monitor with saturating counters and registered readout.
// Optional RAW-adjacency hazard counting is built when FV_COV_HAZARD_EN is defined.
module fv_cov_multi #(
  parameter int          LANES   = 2,
  parameter int          INSTR_W = 32,
  parameter int          CNT_W   = 16,
  parameter int unsigned GOAL    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [LANES-1:0]         instr_valid,
  input  logic [LANES*INSTR_W-1:0] instr,
  input  logic                     rd_en,
  input  logic [3:0]               rd_sel,
  output logic [CNT_W-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [10:0]              class_covered,
  output logic                     all_covered,
  output logic [CNT_W-1:0]         total_cnt,
  output logic [CNT_W-1:0]         hazard_cnt
);

  localparam int NCLS = 11;
  localparam logic [CNT_W-1:0] GOAL_C = CNT_W'(GOAL);

  function automatic logic [3:0] classify(input logic [6:0] op);
    case (op)
      7'b0000011: classify = 4'd0;
      7'b0100011: classify = 4'd1;
      7'b1100011: classify = 4'd2;
      7'b1101111: classify = 4'd3;
      7'b1100111: classify = 4'd4;
      7'b0110011: classify = 4'd5;
      7'b0010011: classify = 4'd6;
      7'b0110111: classify = 4'd7;
      7'b0010111: classify = 4'd8;
      7'b1110011: classify = 4'd9;
      default:    classify = 4'd10;
    endcase
  endfunction

  // Increment is at most LANES (<= 8); one extra bit is enough to detect overflow.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-3){1'b0}}, n};
    sat_add = s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  logic [3:0]       lane_cls_p0 [LANES];
  logic [3:0]       cls_inc_p0  [NCLS];
  logic [3:0]       tot_inc_p0;
  logic [CNT_W-1:0] cls_nxt_p0  [NCLS];
  logic [CNT_W-1:0] rd_mux_p0;
  logic [CNT_W-1:0] cls_cnt_p1  [NCLS];
  logic             unused_instr;

  assign unused_instr = ^instr;

  // p0: per-lane decode and per-class increment counts
  always_comb begin
    tot_inc_p0 = 4'd0;
    for (int k = 0; k < NCLS; k++) cls_inc_p0[k] = 4'd0;
    for (int l = 0; l < LANES; l++) begin
      lane_cls_p0[l] = classify(instr[l*INSTR_W +: 7]);
      if (instr_valid[l]) begin
        tot_inc_p0 = tot_inc_p0 + 4'd1;
        for (int k = 0; k < NCLS; k++)
          if (lane_cls_p0[l] == 4'(k)) cls_inc_p0[k] = cls_inc_p0[k] + 4'd1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NCLS; k++) cls_nxt_p0[k] = sat_add(cls_cnt_p1[k], cls_inc_p0[k]);
  end

  // Readout samples the pre-increment (and pre-clear) counter values.
  always_comb begin
    rd_mux_p0 = '0;
    for (int k = 0; k < NCLS; k++)
      if (rd_sel == 4'(k)) rd_mux_p0 = cls_cnt_p1[k];
    if (rd_sel == 4'd11) rd_mux_p0 = total_cnt;
    if (rd_sel == 4'd12) rd_mux_p0 = hazard_cnt;
  end

  // p1: counters, coverage flags and readout registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NCLS; k++) cls_cnt_p1[k] <= '0;
      total_cnt     <= '0;
      class_covered <= '0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux_p0;
      if (clear) begin
        for (int k = 0; k < NCLS; k++) cls_cnt_p1[k] <= '0;
        total_cnt     <= '0;
        class_covered <= '0;
      end else begin
        for (int k = 0; k < NCLS; k++) begin
          cls_cnt_p1[k]    <= cls_nxt_p0[k];
          class_covered[k] <= (cls_nxt_p0[k] >= GOAL_C);
        end
        total_cnt <= sat_add(total_cnt, tot_inc_p0);
      end
    end
  end

  assign all_covered = &class_covered[9:0];

`ifdef FV_COV_HAZARD_EN
  function automatic logic writes_rd(input logic [3:0] c);
    writes_rd = (c == 4'd0) || (c == 4'd3) || (c == 4'd4) || (c == 4'd5) ||
                (c == 4'd6) || (c == 4'd7) || (c == 4'd8);
  endfunction

  logic       prev_vld_p1;
  logic       prev_wr_p1;
  logic [4:0] prev_rd_p1;
  logic       chain_vld_p0;
  logic       chain_wr_p0;
  logic [4:0] chain_rd_p0;
  logic [3:0] haz_inc_p0;

  // p0: walk lanes in program order, each valid lane becomes the producer for the next
  always_comb begin
    chain_vld_p0 = prev_vld_p1;
    chain_wr_p0  = prev_wr_p1;
    chain_rd_p0  = prev_rd_p1;
    haz_inc_p0   = 4'd0;
    for (int l = 0; l < LANES; l++) begin
      if (instr_valid[l]) begin
        if (chain_vld_p0 && chain_wr_p0 && (chain_rd_p0 != 5'd0) &&
            ((chain_rd_p0 == instr[l*INSTR_W+15 +: 5]) ||
             (chain_rd_p0 == instr[l*INSTR_W+20 +: 5])))
          haz_inc_p0 = haz_inc_p0 + 4'd1;
        chain_vld_p0 = 1'b1;
        chain_wr_p0  = writes_rd(lane_cls_p0[l]);
        chain_rd_p0  = instr[l*INSTR_W+7 +: 5];
      end
    end
  end

  // p1: producer history persists across idle cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_vld_p1 <= 1'b0;
      hazard_cnt  <= '0;
    end else if (clear) begin
      prev_vld_p1 <= 1'b0;
      hazard_cnt  <= '0;
    end else begin
      prev_vld_p1 <= chain_vld_p0;
      hazard_cnt  <= sat_add(hazard_cnt, haz_inc_p0);
    end
  end

  always_ff @(posedge clk) begin
    prev_wr_p1 <= chain_wr_p0;
    prev_rd_p1 <= chain_rd_p0;
  end
`else
  assign hazard_cnt = '0;
`endif

endmodule

// File: tb/tb_fv_cov_multi.sv
// Bench for fv_cov_multi: directed scenarios then random traffic, checked against a
// behavioural model for a wide-counter instance and a 4-bit, GOAL=3 instance.
module tb_fv_cov_multi;
  localparam int LANES = 2;
  localparam int IW    = 32;
`ifdef FV_COV_HAZARD_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset, clear, rd_en;
  logic [LANES-1:0]      instr_valid;
  logic [LANES*IW-1:0]   instr;
  logic [3:0]            rd_sel;

  logic [15:0] a_rd_data, a_total, a_haz;
  logic        a_rd_valid, a_all;
  logic [10:0] a_cov;
  logic [3:0]  b_rd_data, b_total, b_haz;
  logic        b_rd_valid, b_all;
  logic [10:0] b_cov;

  fv_cov_multi #(.LANES(LANES), .INSTR_W(IW), .CNT_W(16), .GOAL(1)) u_dut (
    .clk(clk), .reset(reset), .clear(clear), .instr_valid(instr_valid), .instr(instr),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .class_covered(a_cov), .all_covered(a_all), .total_cnt(a_total), .hazard_cnt(a_haz));

  fv_cov_multi #(.LANES(LANES), .INSTR_W(IW), .CNT_W(4), .GOAL(3)) u_sat (
    .clk(clk), .reset(reset), .clear(clear), .instr_valid(instr_valid), .instr(instr),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .class_covered(b_cov), .all_covered(b_all), .total_cnt(b_total), .hazard_cnt(b_haz));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: index 0 = u_dut, index 1 = u_sat
  int unsigned m_cls [2][11];
  int unsigned m_tot [2];
  int unsigned m_haz [2];
  int unsigned m_rd  [2];
  bit          m_rdv [2];
  bit          p_vld;
  bit          p_wr;
  int unsigned p_rd;

  function automatic int unsigned lim(input int d);
    return (d == 0) ? 32'd65535 : 32'd15;
  endfunction

  function automatic int unsigned goal(input int d);
    return (d == 0) ? 32'd1 : 32'd3;
  endfunction

  function automatic int unsigned sat(input int unsigned a, input int unsigned n, input int d);
    return (a + n > lim(d)) ? lim(d) : a + n;
  endfunction

  function automatic int class_of(input logic [6:0] op);
    case (op)
      7'b0000011: return 0;
      7'b0100011: return 1;
      7'b1100011: return 2;
      7'b1101111: return 3;
      7'b1100111: return 4;
      7'b0110011: return 5;
      7'b0010011: return 6;
      7'b0110111: return 7;
      7'b0010111: return 8;
      7'b1110011: return 9;
      default:    return 10;
    endcase
  endfunction

  function automatic logic [6:0] opc(input int c);
    case (c)
      0: return 7'b0000011;
      1: return 7'b0100011;
      2: return 7'b1100011;
      3: return 7'b1101111;
      4: return 7'b1100111;
      5: return 7'b0110011;
      6: return 7'b0010011;
      7: return 7'b0110111;
      8: return 7'b0010111;
      9: return 7'b1110011;
      default: return 7'b0001111;
    endcase
  endfunction

  function automatic logic [31:0] mk(input int c, input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), opc(c)};
  endfunction

  function automatic logic [31:0] rnd_instr();
    return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
            5'($urandom_range(0, 3)), opc($urandom_range(0, 10))};
  endfunction

  function automatic int unsigned read_val(input int d, input int sel);
    if (sel <= 10) return m_cls[d][sel];
    if (sel == 11) return m_tot[d];
    if (sel == 12) return m_haz[d];
    return 0;
  endfunction

  task automatic model_step();
    int unsigned inc [11];
    int unsigned tinc, hinc;
    int c, rd, rs1, rs2;
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 11; k++) m_cls[d][k] = 0;
        m_tot[d] = 0; m_haz[d] = 0; m_rd[d] = 0; m_rdv[d] = 0;
      end
      p_vld = 0;
      return;
    end
    for (int d = 0; d < 2; d++) begin
      m_rdv[d] = rd_en;
      if (rd_en) m_rd[d] = read_val(d, int'(rd_sel));
    end
    if (clear) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 11; k++) m_cls[d][k] = 0;
        m_tot[d] = 0; m_haz[d] = 0;
      end
      p_vld = 0;
      return;
    end
    for (int k = 0; k < 11; k++) inc[k] = 0;
    tinc = 0; hinc = 0;
    for (int l = 0; l < LANES; l++) begin
      if (instr_valid[l]) begin
        c   = class_of(instr[l*IW +: 7]);
        rd  = int'(instr[l*IW+7 +: 5]);
        rs1 = int'(instr[l*IW+15 +: 5]);
        rs2 = int'(instr[l*IW+20 +: 5]);
        inc[c]++;
        tinc++;
        if (p_vld && p_wr && p_rd != 0 && (p_rd == rs1 || p_rd == rs2)) hinc++;
        p_vld = 1;
        p_rd  = rd;
        p_wr  = (c == 0) || (c >= 3 && c <= 8);
      end
    end
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 11; k++) m_cls[d][k] = sat(m_cls[d][k], inc[k], d);
      m_tot[d] = sat(m_tot[d], tinc, d);
      if (HAZ_EN) m_haz[d] = sat(m_haz[d], hinc, d);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [10:0] cov [2];
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 11; k++) cov[d][k] = (m_cls[d][k] >= goal(d));
    chk("a_total",    32'(a_total),    m_tot[0]);
    chk("a_hazard",   32'(a_haz),      m_haz[0]);
    chk("a_covered",  32'(a_cov),      32'(cov[0]));
    chk("a_all",      32'(a_all),      32'(&cov[0][9:0]));
    chk("a_rd_valid", 32'(a_rd_valid), 32'(m_rdv[0]));
    chk("a_rd_data",  32'(a_rd_data),  m_rd[0]);
    chk("b_total",    32'(b_total),    m_tot[1]);
    chk("b_hazard",   32'(b_haz),      m_haz[1]);
    chk("b_covered",  32'(b_cov),      32'(cov[1]));
    chk("b_all",      32'(b_all),      32'(&cov[1][9:0]));
    chk("b_rd_valid", 32'(b_rd_valid), 32'(m_rdv[1]));
    chk("b_rd_data",  32'(b_rd_data),  m_rd[1]);
  endtask

  task automatic step(input bit rst, input bit clr, input logic [1:0] vld,
                      input logic [63:0] ins, input bit re, input logic [3:0] sel);
    reset = rst; clear = clr; instr_valid = vld; instr = ins; rd_en = re; rd_sel = sel;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'b00, 64'd0, 1'b0, 4'd0);
  endtask

  initial begin
    // Reset, with noise on other inputs that must be ignored
    step(1'b1, 1'b1, 2'b11, {mk(0, 1, 0, 0), mk(0, 1, 0, 0)}, 1'b1, 4'd11);
    step(1'b1, 1'b0, 2'b00, 64'd0, 1'b0, 4'd0);
    chk("reset_total", 32'(a_total), 32'd0);
    chk("reset_rd_valid", 32'(a_rd_valid), 32'd0);
    chk("reset_cov", 32'(a_cov), 32'd0);

    // One instruction of each class 0..9 on lane 0
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b0, 2'b01, {32'd0, mk(c, 0, 0, 0)}, 1'b0, 4'd0);
      if (c == 8) chk("all_before_tenth", 32'(a_all), 32'd0);
    end
    chk("all_on_tenth", 32'(a_all), 32'd1);
    chk("total_ten", 32'(a_total), 32'd10);

    // Bring class 0 to 3, then read it while a LOAD is in flight
    step(1'b0, 1'b0, 2'b01, {32'd0, mk(0, 0, 0, 0)}, 1'b0, 4'd0);
    step(1'b0, 1'b0, 2'b01, {32'd0, mk(0, 0, 0, 0)}, 1'b0, 4'd0);
    step(1'b0, 1'b0, 2'b01, {32'd0, mk(0, 0, 0, 0)}, 1'b1, 4'd0);
    chk("read_cls0_data", 32'(a_rd_data), 32'd3);
    chk("read_cls0_valid", 32'(a_rd_valid), 32'd1);
    idle();
    chk("read_valid_drop", 32'(a_rd_valid), 32'd0);

    // Clear with a concurrent LOAD and total readout
    step(1'b0, 1'b1, 2'b01, {32'd0, mk(0, 0, 0, 0)}, 1'b1, 4'd11);
    chk("clear_read_preclear", 32'(a_rd_data), 32'd13);
    chk("clear_total_zero", 32'(a_total), 32'd0);
    step(1'b0, 1'b0, 2'b00, 64'd0, 1'b1, 4'd0);
    chk("clear_cls0_zero", 32'(a_rd_data), 32'd0);

    // Same-cycle RAW pair, then a cross-idle RAW pair
    step(1'b0, 1'b0, 2'b11, {mk(5, 6, 5, 1), mk(6, 5, 0, 0)}, 1'b0, 4'd0);
    chk("haz_same_cycle", 32'(a_haz), HAZ_EN ? 32'd1 : 32'd0);
    idle(); idle(); idle();
    step(1'b0, 1'b0, 2'b01, {32'd0, mk(1, 0, 2, 6)}, 1'b0, 4'd0);
    chk("haz_across_idle", 32'(a_haz), HAZ_EN ? 32'd2 : 32'd0);
    step(1'b0, 1'b0, 2'b00, 64'd0, 1'b1, 4'd12);
    chk("haz_readout", 32'(a_rd_data), HAZ_EN ? 32'd2 : 32'd0);

    // Saturation of the 4-bit instance: 16 LOADs
    step(1'b0, 1'b1, 2'b00, 64'd0, 1'b0, 4'd0);
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b0, 2'b11, {mk(0, 0, 0, 0), mk(0, 0, 0, 0)}, 1'b0, 4'd0);
    chk("sat_total", 32'(b_total), 32'd15);
    chk("wide_total", 32'(a_total), 32'd16);
    step(1'b0, 1'b0, 2'b00, 64'd0, 1'b1, 4'd0);
    chk("sat_cls0", 32'(b_rd_data), 32'd15);

    // Reset mid-operation discards everything
    step(1'b1, 1'b0, 2'b11, {mk(0, 1, 0, 0), mk(0, 1, 0, 0)}, 1'b0, 4'd0);
    chk("midreset_total", 32'(a_total), 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
           2'($urandom), {rnd_instr(), rnd_instr()},
           $urandom_range(0, 1) == 1, 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
